// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm_if
// Brief    : Instruction/status inputs and datapath control outputs of the
//            multicycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal;
  logic       instr_done;
  logic [3:0] state;

  // Datapath side: supplies instruction fields and status, consumes controls
  modport master (
    output op, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal, instr_done, state
  );

  // Control unit side
  modport slave (
    input  op, funct, zero, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal, instr_done, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Moore FSM sequencing a shared-ALU/shared-memory MIPS datapath.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mc_control_fsm_if.slave   bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd15
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_ok;
  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg;
  logic       w_regwrite, w_alusrca, w_pcwrite, w_branch, w_illegal, w_done;
  logic [1:0] w_alusrcb, w_pcsrc, w_aluop;
  logic [2:0] w_alucontrol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  assign w_funct_ok = (bus.funct == 6'h20) || (bus.funct == 6'h22) ||
                      (bus.funct == 6'h24) || (bus.funct == 6'h25) ||
                      (bus.funct == 6'h2A);

  always_comb begin
    w_next     = S_FETCH;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = c_ALUOP_ADD;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = bus.mem_ready;
        w_pcwrite = bus.mem_ready;
        w_next    = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.op)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_ADDI:        w_next = S_ADDIEX;
          c_OP_J:           w_next = S_JUMP;
          c_OP_RTYPE: begin
            if (w_funct_ok) begin
              w_next = S_EXECUTE;
            end else begin
              w_illegal = 1'b1;
              w_next    = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
            end
          end
          default: begin
            w_illegal = 1'b1;
            w_next    = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.op == c_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_done     = bus.mem_ready;
        w_next     = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = c_ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = c_ALUOP_SUB;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_done    = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
      end
      S_HALT: begin
        w_illegal = 1'b1;
        w_next    = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // ALU decode shared with the single-cycle core
  always_comb begin
    w_alucontrol = 3'b010;
    case (w_aluop)
      c_ALUOP_ADD: w_alucontrol = 3'b010;
      c_ALUOP_SUB: w_alucontrol = 3'b110;
      default: begin
        case (bus.funct)
          6'h20:   w_alucontrol = 3'b010;
          6'h22:   w_alucontrol = 3'b110;
          6'h24:   w_alucontrol = 3'b000;
          6'h25:   w_alucontrol = 3'b001;
          6'h2A:   w_alucontrol = 3'b111;
          default: w_alucontrol = 3'b010;
        endcase
      end
    endcase
  end

  // Write enables and status are gated so nothing commits while reset is high
  assign bus.iord       = w_iord;
  assign bus.memwrite   = w_memwrite & ~reset;
  assign bus.irwrite    = w_irwrite & ~reset;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.regwrite   = w_regwrite & ~reset;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.pcen       = (w_pcwrite | (w_branch & bus.zero)) & ~reset;
  assign bus.alucontrol = w_alucontrol;
  assign bus.illegal    = w_illegal & ~reset;
  assign bus.instr_done = w_done & ~reset;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Self-checking bench: instruction table, corner sequences and
//            randomized instructions against a per-instruction cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if b1();
  mc_control_fsm_if b0();

  mc_control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut (.clk(clk), .reset(reset), .bus(b1.slave));
  mc_control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (.clk(clk), .reset(reset), .bus(b0.slave));

  typedef struct packed {
    logic [3:0] st;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alu;
    logic       illegal, done;
  } outs_t;

  typedef struct {
    logic  mr, zr;
    outs_t o;
    bit    chk_alu;
  } cyc_t;

  typedef struct {
    string      name;
    logic [5:0] op, funct;
    logic       zero;
    int         fw, mw, cyc, regw, memw, pcen;
  } tv_t;

  int   vectors = 0;
  int   miscompares = 0;
  cyc_t q[$];
  tv_t  tab[12];

  function automatic outs_t sample();
    outs_t a;
    a.st = b1.state;        a.iord = b1.iord;         a.memwrite = b1.memwrite;
    a.irwrite = b1.irwrite; a.regdst = b1.regdst;     a.memtoreg = b1.memtoreg;
    a.regwrite = b1.regwrite; a.alusrca = b1.alusrca; a.alusrcb = b1.alusrcb;
    a.pcsrc = b1.pcsrc;     a.pcen = b1.pcen;         a.alu = b1.alucontrol;
    a.illegal = b1.illegal; a.done = b1.instr_done;
    return a;
  endfunction

  function automatic cyc_t mk(logic [3:0] st, logic mr, logic zr);
    cyc_t c;
    c.o = '0;
    c.o.st = st;
    c.mr = mr;
    c.zr = zr;
    c.chk_alu = 1'b0;
    return c;
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_cyc(input string name, input cyc_t c);
    outs_t a, e;
    a = sample();
    e = c.o;
    if (!c.chk_alu) begin
      a.alu = 3'b000;
      e.alu = 3'b000;
    end
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (state %0d)", name, a, e, b1.state);
    end
  endtask

  task automatic step(input logic mr, input logic zr);
    @(negedge clk);
    b1.mem_ready = mr; b1.zero = zr;
    b0.mem_ready = mr; b0.zero = zr;
    #1;
  endtask

  task automatic do_reset();
    cyc_t c;
    @(negedge clk);
    reset = 1'b1;
    b1.mem_ready = 1'b1; b0.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    c = mk(4'd0, 1'b1, 1'b0);
    c.o.alusrcb = 2'b01; c.o.alu = 3'b010; c.chk_alu = 1'b1;
    check_cyc("reset_state", c);
    chk("reset_state_nt", b0.state, 4'd0);
    b1.mem_ready = 1'b0; b0.mem_ready = 1'b0;
    reset = 1'b0;
  endtask

  // Expected per-cycle behaviour of one instruction, from its class and wait counts
  task automatic build(input logic [5:0] op, input logic [5:0] funct, input logic zr,
                       input int fw, input int mw);
    cyc_t c;
    logic [3:0] mst;
    for (int i = 0; i < fw; i++) begin
      c = mk(4'd0, 1'b0, 1'($urandom));
      c.o.alusrcb = 2'b01; c.o.alu = 3'b010; c.chk_alu = 1'b1;
      q.push_back(c);
    end
    c = mk(4'd0, 1'b1, 1'($urandom));
    c.o.alusrcb = 2'b01; c.o.alu = 3'b010; c.chk_alu = 1'b1;
    c.o.irwrite = 1'b1; c.o.pcen = 1'b1;
    q.push_back(c);
    c = mk(4'd1, 1'($urandom), 1'($urandom));
    c.o.alusrcb = 2'b11; c.o.alu = 3'b010; c.chk_alu = 1'b1;
    q.push_back(c);
    case (op)
      6'h23, 6'h2B: begin
        c = mk(4'd2, 1'($urandom), 1'($urandom));
        c.o.alusrca = 1'b1; c.o.alusrcb = 2'b10; c.o.alu = 3'b010; c.chk_alu = 1'b1;
        q.push_back(c);
        mst = (op == 6'h23) ? 4'd3 : 4'd5;
        for (int i = 0; i <= mw; i++) begin
          c = mk(mst, (i == mw), 1'($urandom));
          c.o.iord = 1'b1;
          c.o.memwrite = (op == 6'h2B);
          c.o.done = (op == 6'h2B) && (i == mw);
          q.push_back(c);
        end
        if (op == 6'h23) begin
          c = mk(4'd4, 1'($urandom), 1'($urandom));
          c.o.memtoreg = 1'b1; c.o.regwrite = 1'b1; c.o.done = 1'b1;
          q.push_back(c);
        end
      end
      6'h00: begin
        c = mk(4'd6, 1'($urandom), 1'($urandom));
        c.o.alusrca = 1'b1; c.o.alu = alu_of(funct); c.chk_alu = 1'b1;
        q.push_back(c);
        c = mk(4'd7, 1'($urandom), 1'($urandom));
        c.o.regdst = 1'b1; c.o.regwrite = 1'b1; c.o.done = 1'b1;
        q.push_back(c);
      end
      6'h04: begin
        c = mk(4'd8, 1'($urandom), zr);
        c.o.alusrca = 1'b1; c.o.alu = 3'b110; c.chk_alu = 1'b1;
        c.o.pcsrc = 2'b01; c.o.pcen = zr; c.o.done = 1'b1;
        q.push_back(c);
      end
      6'h08: begin
        c = mk(4'd9, 1'($urandom), 1'($urandom));
        c.o.alusrca = 1'b1; c.o.alusrcb = 2'b10; c.o.alu = 3'b010; c.chk_alu = 1'b1;
        q.push_back(c);
        c = mk(4'd10, 1'($urandom), 1'($urandom));
        c.o.regwrite = 1'b1; c.o.done = 1'b1;
        q.push_back(c);
      end
      6'h02: begin
        c = mk(4'd11, 1'($urandom), 1'($urandom));
        c.o.pcsrc = 2'b10; c.o.pcen = 1'b1; c.o.done = 1'b1;
        q.push_back(c);
      end
      default: ;
    endcase
  endtask

  task automatic run_vec(input tv_t tv);
    int  fw_left, mw_left, cycles, regw, memw, pc;
    bit  done;
    logic mr;
    b1.op = tv.op; b1.funct = tv.funct;
    fw_left = tv.fw; mw_left = tv.mw;
    cycles = 0; regw = 0; memw = 0; pc = 0; done = 1'b0;
    while (!done && cycles < 30) begin
      @(negedge clk);
      mr = 1'b1;
      if (b1.state == 4'd0 && fw_left > 0) begin
        mr = 1'b0; fw_left--;
      end else if ((b1.state == 4'd3 || b1.state == 4'd5) && mw_left > 0) begin
        mr = 1'b0; mw_left--;
      end
      b1.mem_ready = mr; b1.zero = tv.zero;
      #1;
      cycles++;
      regw += int'(b1.regwrite);
      memw += int'(b1.memwrite);
      pc   += int'(b1.pcen);
      if (b1.instr_done) done = 1'b1;
    end
    if (!done) $display("FAIL %s_timeout: no instr_done within %0d cycles", tv.name, cycles);
    chk({tv.name, "_cycles"}, cycles, tv.cyc);
    chk({tv.name, "_regwrite"}, regw, tv.regw);
    chk({tv.name, "_memwrite"}, memw, tv.memw);
    chk({tv.name, "_pcen"}, pc, tv.pcen);
  endtask

  initial begin
    cyc_t c;
    int   k;
    logic [5:0] rop, rfn;
    int   rfw, rmw;

    //            name     op     funct  z  fw mw cyc rw mw pcen
    tab[0]  = '{"add",    6'h00, 6'h20, 0, 0, 0, 4, 1, 0, 1};
    tab[1]  = '{"sub_w",  6'h00, 6'h22, 0, 1, 0, 5, 1, 0, 1};
    tab[2]  = '{"and",    6'h00, 6'h24, 0, 0, 0, 4, 1, 0, 1};
    tab[3]  = '{"or",     6'h00, 6'h25, 1, 0, 0, 4, 1, 0, 1};
    tab[4]  = '{"slt",    6'h00, 6'h2A, 0, 0, 0, 4, 1, 0, 1};
    tab[5]  = '{"lw_w",   6'h23, 6'h00, 0, 2, 1, 8, 1, 0, 1};
    tab[6]  = '{"lw",     6'h23, 6'h00, 0, 0, 0, 5, 1, 0, 1};
    tab[7]  = '{"sw_w",   6'h2B, 6'h00, 0, 0, 2, 6, 0, 3, 1};
    tab[8]  = '{"beq_t",  6'h04, 6'h00, 1, 0, 0, 3, 0, 0, 2};
    tab[9]  = '{"beq_n",  6'h04, 6'h00, 0, 0, 0, 3, 0, 0, 1};
    tab[10] = '{"addi",   6'h08, 6'h00, 0, 0, 0, 4, 1, 0, 1};
    tab[11] = '{"j",      6'h02, 6'h00, 0, 0, 0, 3, 0, 0, 2};

    b1.op = 6'h00; b1.funct = 6'h20; b1.zero = 1'b0; b1.mem_ready = 1'b1;
    b0.op = 6'h3F; b0.funct = 6'h00; b0.zero = 1'b0; b0.mem_ready = 1'b1;

    // Illegal encodings: trapping instance halts, non-trapping one loops back to FETCH
    for (int t = 0; t < 2; t++) begin
      do_reset();
      b1.op = (t == 0) ? 6'h3F : 6'h00;
      b1.funct = (t == 0) ? 6'h00 : 6'h21;
      b0.op = b1.op; b0.funct = b1.funct;
      for (int i = 0; i < 6; i++) begin
        step(1'b1, 1'b0);
        if (i == 0) begin
          c = mk(4'd0, 1'b1, 1'b0);
          c.o.alusrcb = 2'b01; c.o.alu = 3'b010; c.chk_alu = 1'b1;
          c.o.irwrite = 1'b1; c.o.pcen = 1'b1;
        end else if (i == 1) begin
          c = mk(4'd1, 1'b1, 1'b0);
          c.o.alusrcb = 2'b11; c.o.alu = 3'b010; c.chk_alu = 1'b1;
          c.o.illegal = 1'b1;
        end else begin
          c = mk(4'd15, 1'b1, 1'b0);
          c.o.illegal = 1'b1;
        end
        check_cyc("illegal_trap", c);
        chk("illegal_notrap", {b0.state, b0.illegal}, {((i % 2) == 1) ? 4'd1 : 4'd0, (i % 2) == 1});
      end
    end

    do_reset();
    foreach (tab[i]) run_vec(tab[i]);

    // Reset while a store waits on memory: the write enable must drop at once
    b1.op = 6'h2B; b1.funct = 6'h00;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("sw_memwr", {b1.state, b1.memwrite, b1.iord}, {4'd5, 1'b1, 1'b1});
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("rst_abort", {b1.state, b1.memwrite, b1.regwrite, b1.instr_done}, {4'd0, 3'b000});
    b1.mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0);
    chk("rst_resume_wait", {b1.state, b1.irwrite, b1.pcen}, {4'd0, 2'b00});
    step(1'b1, 1'b0);
    chk("rst_resume_fetch", {b1.state, b1.irwrite, b1.pcen}, {4'd0, 2'b11});
    step(1'b1, 1'b0);
    chk("rst_resume_decode", b1.state, 4'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      rfn = 6'h00;
      case (k)
        0: begin rop = 6'h00; rfn = 6'h20; end
        1: begin rop = 6'h00; rfn = 6'h22; end
        2: begin rop = 6'h00; rfn = 6'h24; end
        3: begin rop = 6'h00; rfn = 6'h25; end
        4: begin rop = 6'h00; rfn = 6'h2A; end
        5: rop = 6'h23;
        6: rop = 6'h2B;
        7: rop = 6'h04;
        8: rop = 6'h08;
        default: rop = 6'h02;
      endcase
      rfw = $urandom_range(0, 2);
      rmw = $urandom_range(0, 2);
      b1.op = rop; b1.funct = rfn;
      q.delete();
      build(rop, rfn, 1'($urandom), rfw, rmw);
      while (q.size() > 0) begin
        c = q.pop_front();
        step(c.mr, c.zr);
        check_cyc("random", c);
      end
    end
    step(1'b0, 1'b0);
    chk("final_fetch", b1.state, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
